// File: rtl/rs_chien_pkg.sv
// Shared constants and FSM encoding for the RS(255) Chien/Forney coefficient path.
package rs_chien_pkg;

    localparam int COEF_W    = 8;
    localparam int NUM_COEFS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/errata_coef_streamer_coef_bank.sv
// Coefficient register bank: synchronous write, zero-masked combinational read.
module coef_bank
    import rs_chien_pkg::*;
#(
    parameter int AW   = 5,
    parameter int LAST = NUM_COEFS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [COEF_W-1:0] i_data,
    input  logic [AW-1:0]     i_raddr,
    output logic [COEF_W-1:0] o_rdata
);

    localparam logic [AW:0] LP_LAST = (AW+1)'(LAST);

    logic [COEF_W-1:0] r_mem [0:LAST];
    logic [LAST:0]     r_vld;
    logic              w_in_range;

    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_vld <= '0;
        end else if (i_we) begin
            r_vld[i_addr] <= 1'b1;
            r_mem[i_addr] <= i_data;
        end
    end

    assign w_in_range = ({1'b0, i_raddr} <= LP_LAST);

    // Entries never written since the last clear read as zero.
    always_comb begin
        o_rdata = '0;
        if (w_in_range && r_vld[i_raddr])
            o_rdata = r_mem[i_raddr];
    end

endmodule

// File: rtl/errata_coef_streamer.sv
// Errata coefficient transmit side for one decoder lane.
// FULL_FLUSH_EN: stream every index up to number_of_coefs, not just up to the degree.
module errata_coef_streamer
    import rs_chien_pkg::*;
#(
    parameter int width           = 5,
    parameter int number_of_coefs = NUM_COEFS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              new_cw,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [width-1:0]  wr_addr,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              mea_done,
    input  logic [width-1:0]  mea_degree,
    input  logic              send_loc_errata_coefs,
    input  logic              send_magnitude_errata_coefs,
    output logic [COEF_W-1:0] errata_loc_coefs,
    output logic [width-1:0]  errata_loc_addr,
    output logic              errata_loc_coef_ready,
    output logic [COEF_W-1:0] errata_magnitude_coefs,
    output logic [width-1:0]  errata_magnitude_addr,
    output logic              errata_magnitude_coef_ready,
    output logic              MEA_compute_done,
    output logic [width-1:0]  locator_degree,
    output logic              stream_done,
    output logic              wr_error
);

    localparam logic [width:0] LP_MAX = (width+1)'(number_of_coefs);

    state_t            r_state, w_nxt_state;
    logic [width:0]    r_cnt, w_nxt_cnt, w_end;
    logic [width-1:0]  r_deg, w_nxt_deg;
    logic [width-1:0]  r_addr, w_nxt_addr;
    logic              r_ready, w_nxt_ready;
    logic              r_mcd, w_nxt_mcd;
    logic              r_sd, w_nxt_sd;
    logic              r_err;
    logic [COEF_W-1:0] r_loc, r_mag;
    logic [COEF_W-1:0] w_loc_rd, w_mag_rd;
    logic              w_idle, w_wr_ok, w_wr_bad, w_deg_bad;

    assign w_idle    = (r_state == IDLE) && !new_cw;
    assign w_wr_ok   = wr_en && w_idle && ({1'b0, wr_addr} <= LP_MAX);
    assign w_wr_bad  = wr_en && !new_cw &&
                       ((r_state != IDLE) || ({1'b0, wr_addr} > LP_MAX));
    assign w_deg_bad = mea_done && w_idle && ({1'b0, mea_degree} > LP_MAX);

`ifdef FULL_FLUSH_EN
    assign w_end = LP_MAX;
`else
    assign w_end = {1'b0, r_deg};
`endif

    coef_bank #(.AW(width), .LAST(number_of_coefs)) u_loc_bank (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (new_cw),
        .i_we    (w_wr_ok && !wr_sel),
        .i_addr  (wr_addr),
        .i_data  (wr_data),
        .i_raddr (r_cnt[width-1:0]),
        .o_rdata (w_loc_rd)
    );

    coef_bank #(.AW(width), .LAST(number_of_coefs)) u_mag_bank (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (new_cw),
        .i_we    (w_wr_ok && wr_sel),
        .i_addr  (wr_addr),
        .i_data  (wr_data),
        .i_raddr (r_cnt[width-1:0]),
        .o_rdata (w_mag_rd)
    );

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_deg   = r_deg;
        w_nxt_addr  = r_addr;
        w_nxt_ready = 1'b0;
        w_nxt_mcd   = r_mcd;
        w_nxt_sd    = r_sd;
        if (new_cw) begin
            w_nxt_state = IDLE;
            w_nxt_cnt   = '0;
            w_nxt_deg   = '0;
            w_nxt_addr  = '0;
            w_nxt_mcd   = 1'b0;
            w_nxt_sd    = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (mea_done) begin
                        w_nxt_state = LOADED;
                        w_nxt_deg   = w_deg_bad ? LP_MAX[width-1:0] : mea_degree;
                        w_nxt_mcd   = 1'b1;
                        w_nxt_cnt   = '0;
                        w_nxt_addr  = '0;
                    end
                end
                LOADED: begin
                    w_nxt_addr = '0;
                    if (send_loc_errata_coefs || send_magnitude_errata_coefs) begin
                        w_nxt_state = STREAM;
                        w_nxt_cnt   = '0;
                    end
                end
                STREAM: begin
                    w_nxt_ready = 1'b1;
                    w_nxt_addr  = r_cnt[width-1:0];
                    w_nxt_cnt   = r_cnt + 1'b1;
                    if (r_cnt == w_end)
                        w_nxt_state = DONE;
                end
                DONE: begin
                    // Counter already sits one past the last index sent.
                    w_nxt_addr = r_cnt[width-1:0];
                    w_nxt_sd   = 1'b1;
                end
                default: w_nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= '0;
            r_deg   <= '0;
            r_addr  <= '0;
            r_ready <= 1'b0;
            r_mcd   <= 1'b0;
            r_sd    <= 1'b0;
            r_loc   <= '0;
            r_mag   <= '0;
        end else begin
            r_cnt   <= w_nxt_cnt;
            r_deg   <= w_nxt_deg;
            r_addr  <= w_nxt_addr;
            r_ready <= w_nxt_ready;
            r_mcd   <= w_nxt_mcd;
            r_sd    <= w_nxt_sd;
            r_loc   <= w_nxt_ready ? w_loc_rd : '0;
            r_mag   <= w_nxt_ready ? w_mag_rd : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_err <= 1'b0;
        else if (w_wr_bad || w_deg_bad)
            r_err <= 1'b1;
    end

    assign errata_loc_coefs            = r_loc;
    assign errata_loc_addr             = r_addr;
    assign errata_loc_coef_ready       = r_ready;
    assign errata_magnitude_coefs      = r_mag;
    assign errata_magnitude_addr       = r_addr;
    assign errata_magnitude_coef_ready = r_ready;
    assign MEA_compute_done            = r_mcd;
    assign locator_degree              = r_deg;
    assign stream_done                 = r_sd;
    assign wr_error                    = r_err;

endmodule

// File: tb/tb_errata_coef_streamer.sv
// Directed bench for errata_coef_streamer; follows FULL_FLUSH_EN like the DUT.
module tb_errata_coef_streamer;

    logic       clock = 1'b0;
    logic       reset;
    logic       new_cw, wr_en, wr_sel, mea_done;
    logic [4:0] wr_addr, mea_degree;
    logic [7:0] wr_data;
    logic       send_loc, send_mag;
    logic [7:0] loc_c, mag_c;
    logic [4:0] loc_a, mag_a, deg_o;
    logic       loc_r, mag_r, mcd, sd, werr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] cap_l  [0:31];
    logic [7:0] cap_m  [0:31];
    logic [4:0] cap_la [0:31];
    logic [4:0] cap_ma [0:31];
    int         n_cap;

    errata_coef_streamer dut (
        .clock                       (clock),
        .reset                       (reset),
        .new_cw                      (new_cw),
        .wr_en                       (wr_en),
        .wr_sel                      (wr_sel),
        .wr_addr                     (wr_addr),
        .wr_data                     (wr_data),
        .mea_done                    (mea_done),
        .mea_degree                  (mea_degree),
        .send_loc_errata_coefs       (send_loc),
        .send_magnitude_errata_coefs (send_mag),
        .errata_loc_coefs            (loc_c),
        .errata_loc_addr             (loc_a),
        .errata_loc_coef_ready       (loc_r),
        .errata_magnitude_coefs      (mag_c),
        .errata_magnitude_addr       (mag_a),
        .errata_magnitude_coef_ready (mag_r),
        .MEA_compute_done            (mcd),
        .locator_degree              (deg_o),
        .stream_done                 (sd),
        .wr_error                    (werr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wr(input logic sel, input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic mea(input logic [4:0] d);
        mea_done = 1'b1; mea_degree = d;
        tick();
        mea_done = 1'b0;
    endtask

    task automatic pulse_new_cw();
        new_cw = 1'b1;
        tick();
        new_cw = 1'b0;
    endtask

    task automatic stream();
        n_cap = 0;
        send_loc = 1'b1; send_mag = 1'b1;
        tick();
        send_loc = 1'b0; send_mag = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (loc_r) begin
                if (n_cap < 32) begin
                    cap_l[n_cap]  = loc_c;
                    cap_m[n_cap]  = mag_c;
                    cap_la[n_cap] = loc_a;
                    cap_ma[n_cap] = mag_a;
                end
                n_cap++;
            end
            if (sd) break;
        end
        check("stream_ends", {31'd0, sd}, 32'd1);
    endtask

    function automatic int n_exp(input int deg);
`ifdef FULL_FLUSH_EN
        return 17;
`else
        return deg + 1;
`endif
    endfunction

    initial begin
        logic [7:0] el [0:2];
        logic [7:0] em [0:2];
        el[0] = 8'h01; el[1] = 8'h0A; el[2] = 8'h33;
        em[0] = 8'h05; em[1] = 8'h07; em[2] = 8'h00;
        new_cw = 0; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0;
        mea_done = 0; mea_degree = 0; send_loc = 0; send_mag = 0;
        do_reset();

        check("rst_ready", {31'd0, loc_r | mag_r}, 32'd0);
        check("rst_addr", {22'd0, loc_a, mag_a}, 32'd0);
        check("rst_mcd", {31'd0, mcd}, 32'd0);
        check("rst_sd", {31'd0, sd}, 32'd0);
        check("rst_err", {31'd0, werr}, 32'd0);
        check("rst_deg", {27'd0, deg_o}, 32'd0);

        wr(1'b0, 5'd0, 8'h01);
        wr(1'b0, 5'd1, 8'h0A);
        wr(1'b0, 5'd2, 8'h33);
        wr(1'b1, 5'd0, 8'h05);
        wr(1'b1, 5'd1, 8'h07);
        mea(5'd2);
        check("t1_mcd", {31'd0, mcd}, 32'd1);
        check("t1_deg", {27'd0, deg_o}, 32'd2);
        check("t1_addr0", {27'd0, loc_a}, 32'd0);
        stream();
        check("t1_n", n_cap, n_exp(2));
        for (int i = 0; i < n_exp(2) && i < 32; i++) begin
            check($sformatf("t1_la%0d", i), {27'd0, cap_la[i]}, i);
            check($sformatf("t1_ma%0d", i), {27'd0, cap_ma[i]}, i);
            check($sformatf("t1_l%0d", i), {24'd0, cap_l[i]},
                  i < 3 ? {24'd0, el[i]} : 32'd0);
            check($sformatf("t1_m%0d", i), {24'd0, cap_m[i]},
                  i < 3 ? {24'd0, em[i]} : 32'd0);
        end
        check("t1_rdy_off", {31'd0, loc_r | mag_r}, 32'd0);
        check("t1_park_l", {27'd0, loc_a}, n_exp(2));
        check("t1_park_m", {27'd0, mag_a}, n_exp(2));
        check("t1_sd", {31'd0, sd}, 32'd1);
        check("t1_err", {31'd0, werr}, 32'd0);

        pulse_new_cw();
        check("t2_clr_sd", {31'd0, sd}, 32'd0);
        wr(1'b0, 5'd0, 8'h01);
        mea(5'd0);
        stream();
        check("t2_n", n_cap, n_exp(0));
        check("t2_a0", {27'd0, cap_la[0]}, 32'd0);
        check("t2_l0", {24'd0, cap_l[0]}, 32'h01);
        check("t2_park", {27'd0, loc_a}, n_exp(0));
        check("t2_mcd", {31'd0, mcd}, 32'd1);

        pulse_new_cw();
        mea(5'd20);
        check("t3_deg", {27'd0, deg_o}, 32'd16);
        check("t3_err", {31'd0, werr}, 32'd1);
        stream();
        check("t3_n", n_cap, 17);
        check("t3_last", {27'd0, cap_la[16]}, 32'd16);
        check("t3_park", {27'd0, mag_a}, 32'd17);

        do_reset();
        wr(1'b0, 5'd0, 8'hAB);
        wr(1'b0, 5'd1, 8'hCD);
        mea(5'd2);
        send_loc = 1'b1; send_mag = 1'b1;
        tick();
        send_loc = 1'b0; send_mag = 1'b0;
        tick();
        check("t4_r0", {31'd0, loc_r}, 32'd1);
        check("t4_l0", {24'd0, loc_c}, 32'hAB);
        tick();
        check("t4_a1", {27'd0, loc_a}, 32'd1);
        check("t4_l1", {24'd0, loc_c}, 32'hCD);
        pulse_new_cw();
        check("t4_rdy", {31'd0, loc_r | mag_r}, 32'd0);
        check("t4_mcd", {31'd0, mcd}, 32'd0);
        check("t4_addr", {27'd0, loc_a}, 32'd0);
        mea(5'd0);
        check("t4_idle", {31'd0, mcd}, 32'd1);
        stream();
        check("t4_stale", {24'd0, cap_l[0]}, 32'h00);

        do_reset();
        wr(1'b0, 5'd0, 8'h11);
        wr(1'b0, 5'd1, 8'h22);
        mea(5'd1);
        check("t5_err0", {31'd0, werr}, 32'd0);
        wr(1'b0, 5'd0, 8'h99);
        check("t5_err_ld", {31'd0, werr}, 32'd1);
        stream();
        check("t5_n", n_cap, n_exp(1));
        check("t5_l0", {24'd0, cap_l[0]}, 32'h11);
        check("t5_l1", {24'd0, cap_l[1]}, 32'h22);

        do_reset();
        wr(1'b0, 5'd17, 8'hFF);
        check("t5_err17", {31'd0, werr}, 32'd1);
        new_cw = 1'b1;
        wr(1'b0, 5'd0, 8'h55);
        new_cw = 1'b0;
        mea(5'd0);
        stream();
        check("t5_ncw_wr", {24'd0, cap_l[0]}, 32'h00);
        check("t5_err_stk", {31'd0, werr}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/errata_coef_streamer.md
Name: errata_coef_streamer

Overview:
Transmit side of the errata-coefficient handshake in the three-lane RS(255) decoder; one instance per lane.
- Captures the errata locator (sigma) and errata magnitude (omega) coefficients written by the MEA core.
- Announces completion with MEA_compute_done and locator_degree.
- Streams coefficients indexed 0..degree, one per cycle, to the Chien/Forney unit while that unit holds its send requests high.

Parameters:
width, 5, bit width of coefficient address and degree.
number_of_coefs, 16, highest coefficient index; each bank holds number_of_coefs+1 entries.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
new_cw  in  1  pulse; start of a new codeword, clears banks and returns to IDLE
wr_en  in  1  MEA coefficient write strobe
wr_sel  in  1  0 = locator bank, 1 = magnitude bank
wr_addr  in  width  coefficient index
wr_data  in  8  GF(2^8) coefficient
mea_done  in  1  pulse; MEA finished, latch degree
mea_degree  in  width  locator polynomial degree
send_loc_errata_coefs  in  1  receiver request, locator stream
send_magnitude_errata_coefs  in  1  receiver request, magnitude stream
errata_loc_coefs  out  8  locator coefficient
errata_loc_addr  out  width  locator coefficient index
errata_loc_coef_ready  out  1  locator coefficient valid this cycle
errata_magnitude_coefs  out  8  magnitude coefficient
errata_magnitude_addr  out  width  magnitude coefficient index
errata_magnitude_coef_ready  out  1  magnitude coefficient valid this cycle
MEA_compute_done  out  1  level; coefficients available
locator_degree  out  width  latched degree
stream_done  out  1  level; all coefficients sent
wr_error  out  1  sticky; write outside IDLE, or index > number_of_coefs

Behaviour:
- Reset values: all outputs 0, both addresses 0, state IDLE, all valid bits clear.
- States:
  - IDLE: accept writes. Write to an index > number_of_coefs is dropped and sets wr_error. mea_done latches the degree and moves to LOADED. If mea_degree > number_of_coefs, the degree is clamped to number_of_coefs and wr_error is set.
  - LOADED: MEA_compute_done=1, addresses held at 0. When either send input is sampled high, go to STREAM.
  - STREAM: each cycle drive coef[cnt] on both data outputs, cnt on both addresses, both ready strobes =1, then cnt++. After the cycle that sends index end_idx, go to DONE.
    - end_idx = locator_degree; with FULL_FLUSH_EN, end_idx = number_of_coefs.
  - DONE: ready=0, stream_done=1, MEA_compute_done stays 1, both addresses parked at end_idx+1.
- Address arithmetic: addresses are computed in width+1 bits internally, then truncated. With the defaults, 17 fits in 5 bits. The receiver therefore sees addr > degree and stops requesting.
- Latency: first ready strobe appears 1 cycle after a send input is sampled high in LOADED. A full stream takes end_idx+1 consecutive ready cycles, with no gaps.
- Once in STREAM, the stream does not stall if send drops; the receiver drops send itself once addr > degree.
- Unwritten entries (valid bit clear) read as 8'h00.
- Address and ready outputs are registered; data is registered in the same cycle as its address.
- new_cw in any state: clear valid bits, ready=0, MEA_compute_done=0, stream_done=0, addresses=0, go to IDLE. wr_error is cleared only by reset.
- If new_cw and wr_en are both high in IDLE, new_cw wins and the write is discarded.
- Reset mid-stream: immediate return to reset values. Any partial data in the receiver is abandoned.
- mea_done outside IDLE is ignored.
- Degree 0: exactly one coefficient (index 0) is sent, then addresses park at 1.

Optional Feature:
FULL_FLUSH_EN
- Defined: stream all indices 0..number_of_coefs; entries above the degree are sent as 00. This overwrites stale receiver registers, because the receiver does not reset its coefficient arrays. The receiver must keep its write enable tied to ready, not to its own request.
- Undefined: stream stops after index locator_degree.

Decomposition:
- Package rs_chien_pkg holds:
  - COEF_W=8;
  - NUM_COEFS=16;
  - the state encoding (IDLE, LOADED, STREAM, DONE).
- Sub-module coef_bank: (number_of_coefs+1) x 8 register array with valid bits, synchronous write, combinational zero-masked read, and clear. It is instantiated twice, for locator and magnitude.
- The FSM and counter live in the top module.

Test Plan:
- Write loc {01,0A,33} and mag {05,07} at idx 0..2/0..1, mea_done with degree=2, raise both sends → 3 ready cycles carrying addr 0,1,2 with loc 01,0A,33 and mag 05,07,00. Then ready=0, addresses=3, stream_done=1.
- Degree 0 with loc[0]=01 → single ready cycle at addr 0, addresses park at 1, MEA_compute_done stays 1.
- mea_degree=20 → locator_degree=16, wr_error=1; stream covers 0..16 and addresses park at 17.
- new_cw asserted during the 2nd stream cycle → ready=0 next cycle, MEA_compute_done=0, state IDLE. A subsequent read of previously written idx 0 returns 00.
- Write while in LOADED, and a write to idx 17 in IDLE → both writes dropped, wr_error=1; streamed data is unchanged.
- FULL_FLUSH_EN, degree 2 → 17 ready cycles, idx 3..16 carry 00, addresses park at 17.
